park_ctrl: RTL

Parametrised multi-slot parking controller, the successor to the single-gate password parker. Handles entry requests (password check, duplicate and full checks, lowest-free-slot allocation) and exit requests (vehicle-number lookup, slot release). Drives timed front and back gates, tracks occupancy, and locks out after repeated bad passwords. Sits between the gate/keypad front-end and the status display.

---
 rtl/park_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/park_ctrl.sv
// park_ctrl: multi-slot parking controller with password entry, exit lookup,
// timed front/back gates, occupancy tracking and bad-password lockout.
module park_ctrl #(
    parameter int              N_SLOTS     = 16,
    parameter int              VN_W        = 4,
    parameter int              PW_W        = 4,
    parameter logic [PW_W-1:0] PASSWORD    = 4'b1010,
    parameter int              MAX_TRIES   = 3,
    parameter int              GATE_CYCLES = 4,
    parameter int              LOCK_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         entry_req,
    input  logic                         exit_req,
    input  logic [PW_W-1:0]              pswd,
    input  logic [VN_W-1:0]              vn,
    output logic                         front,
    output logic                         back,
    output logic [$clog2(N_SLOTS)-1:0]   slot_idx,
    output logic                         slot_valid,
    output logic [$clog2(N_SLOTS+1)-1:0] occupancy,
    output logic                         full,
    output logic                         err,
    output logic [2:0]                   err_code,
    output logic                         locked
);
    localparam int IW   = $clog2(N_SLOTS);
    localparam int OW   = $clog2(N_SLOTS + 1);
    localparam int TMAX = (GATE_CYCLES > LOCK_CYCLES) ? GATE_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {IDLE, CHECK, ENTRY_OPEN, EXIT_CHK, EXIT_OPEN, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [PW_W-1:0]   pswd_q, pswd_d;
    logic [VN_W-1:0]   vn_q, vn_d;
    logic [N_SLOTS-1:0] valid_q, valid_d;
    logic [VN_W-1:0]   tab_q [N_SLOTS];
    logic [VN_W-1:0]   tab_d [N_SLOTS];
    logic [OW-1:0]     occ_q, occ_d;
    logic [FW-1:0]     fail_q, fail_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [IW-1:0]     slot_idx_q, slot_idx_d;
    logic [2:0]        err_code_q, err_code_d;
    logic              front_q, front_d, back_q, back_d, locked_q, locked_d;
    logic              slot_valid_q, slot_valid_d, err_q, err_d;
    logic [IW-1:0]     free_idx, hit_idx;
    logic              hit, full_w;

    assign full_w = occ_q == OW'(N_SLOTS);

    // Descending scan so the last assignment wins with the lowest index.
    always_comb begin
        free_idx = '0;
        hit_idx  = '0;
        hit      = 1'b0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IW'(i);
            if (valid_q[i] && tab_q[i] == vn_q) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pswd_d       = pswd_q;
        vn_d         = vn_q;
        valid_d      = valid_q;
        tab_d        = tab_q;
        occ_d        = occ_q;
        fail_d       = fail_q;
        tmr_d        = tmr_q;
        slot_idx_d   = slot_idx_q;
        err_code_d   = err_code_q;
        front_d      = front_q;
        back_d       = back_q;
        locked_d     = locked_q;
        slot_valid_d = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (entry_req) begin
                    pswd_d  = pswd;
                    vn_d    = vn;
                    state_d = CHECK;
                end else if (exit_req) begin
                    vn_d    = vn;
                    state_d = EXIT_CHK;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (pswd_q != PASSWORD) begin
                    err_d      = 1'b1;
                    err_code_d = 3'd1;
                    fail_d     = fail_q + 1'b1;
                    if (fail_d == FW'(MAX_TRIES)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        tmr_d    = TW'(LOCK_CYCLES - 1);
                    end
                end else if (full_w || hit) begin
                    err_d      = 1'b1;
                    err_code_d = full_w ? 3'd2 : 3'd3;
                    fail_d     = '0;
                end else begin
                    valid_d[free_idx] = 1'b1;
                    tab_d[free_idx]   = vn_q;
                    slot_idx_d        = free_idx;
                    slot_valid_d      = 1'b1;
                    occ_d             = occ_q + 1'b1;
                    fail_d            = '0;
                    front_d           = 1'b1;
                    tmr_d             = TW'(GATE_CYCLES - 1);
                    state_d           = ENTRY_OPEN;
                end
            end
            EXIT_CHK: begin
                if (hit) begin
                    valid_d[hit_idx] = 1'b0;
                    slot_idx_d       = hit_idx;
                    slot_valid_d     = 1'b1;
                    occ_d            = occ_q - 1'b1;
                    back_d           = 1'b1;
                    tmr_d            = TW'(GATE_CYCLES - 1);
                    state_d          = EXIT_OPEN;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = 3'd4;
                    state_d    = IDLE;
                end
            end
            ENTRY_OPEN, EXIT_OPEN, LOCKED: begin
                if (tmr_q == '0) begin
                    front_d  = 1'b0;
                    back_d   = 1'b0;
                    locked_d = 1'b0;
                    fail_d   = (state_q == LOCKED) ? '0 : fail_q;
                    state_d  = IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pswd_q       <= '0;
            vn_q         <= '0;
            valid_q      <= '0;
            occ_q        <= '0;
            fail_q       <= '0;
            tmr_q        <= '0;
            slot_idx_q   <= '0;
            err_code_q   <= '0;
            front_q      <= 1'b0;
            back_q       <= 1'b0;
            locked_q     <= 1'b0;
            slot_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pswd_q       <= pswd_d;
            vn_q         <= vn_d;
            valid_q      <= valid_d;
            occ_q        <= occ_d;
            fail_q       <= fail_d;
            tmr_q        <= tmr_d;
            slot_idx_q   <= slot_idx_d;
            err_code_q   <= err_code_d;
            front_q      <= front_d;
            back_q       <= back_d;
            locked_q     <= locked_d;
            slot_valid_q <= slot_valid_d;
            err_q        <= err_d;
        end
    end

    // Stored vehicle numbers are only meaningful where the valid bit is set.
    always_ff @(posedge clk) tab_q <= tab_d;

    assign front      = front_q;
    assign back       = back_q;
    assign slot_idx   = slot_idx_q;
    assign slot_valid = slot_valid_q;
    assign occupancy  = occ_q;
    assign full       = full_w;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign locked     = locked_q;
endmodule
